// File: rtl/conv_frame_sequencer_if.sv
// Bundle of signals between the frame sequencer and its input RAM, convolution engine and output RAM.
// The master modport is the sequencer side. The slave modport is the environment side.
interface conv_frame_sequencer_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_W     = 10,
    parameter int OUT_ADDR_W = 10
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] conv_data_in;
    logic                  conv_valid_in;
    logic [DATA_WIDTH-1:0] conv_data_out;
    logic                  conv_valid_out;
    logic                  wr_en;
    logic [OUT_ADDR_W-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  start,
        output busy, done, error,
        output rd_en, rd_addr,
        input  rd_data,
        output conv_data_in, conv_valid_in,
        input  conv_data_out, conv_valid_out,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        output start,
        input  busy, done, error,
        input  rd_en, rd_addr,
        output rd_data,
        input  conv_data_in, conv_valid_in,
        output conv_data_out, conv_valid_out,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame controller for a streaming 2-D convolution engine. It streams one frame out of the input RAM
// and writes only the full-window (non-border) results to the output RAM.
module conv_frame_sequencer #(
    parameter int DATA_WIDTH = 24,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int K          = 5,
    parameter int ADDR_W     = 10,
    parameter int OUT_ADDR_W = 10,
    parameter int TIMEOUT    = 1024
) (
    input logic clk,
    input logic rst,
    conv_frame_sequencer_if.master bus
);
    localparam int N      = IMG_W * IMG_H;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int RET_W  = (N > 1) ? $clog2(N) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]  COL_MIN   = COL_W'(K - 1);
    localparam logic [ROW_W-1:0]  ROW_MIN   = ROW_W'(K - 1);
    localparam logic [RET_W-1:0]  RET_LAST  = RET_W'(N - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                  state;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    conv_valid_in;
    logic [OUT_ADDR_W-1:0]   wr_addr;
    logic [COL_W-1:0]        out_col;
    logic [ROW_W-1:0]        out_row;
    logic [RET_W-1:0]        ret_cnt;
    logic [IDLE_W-1:0]       idle_cnt;

    logic ret_ok;
    logic last_ret;
    logic wr_en;

    // Engine results only count while a frame is in flight; stragglers after a reset are dropped.
    assign ret_ok   = bus.conv_valid_out & busy;
    assign last_ret = ret_ok & (ret_cnt == RET_LAST);
    assign wr_en    = ret_ok & (out_row >= ROW_MIN) & (out_col >= COL_MIN);

    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.error         = error;
    assign bus.rd_en         = rd_en;
    assign bus.rd_addr       = rd_addr;
    assign bus.conv_data_in  = bus.rd_data;
    assign bus.conv_valid_in = conv_valid_in;
    assign bus.wr_en         = wr_en;
    assign bus.wr_addr       = wr_addr;
    assign bus.wr_data       = bus.conv_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            conv_valid_in <= 1'b0;
            wr_addr       <= '0;
            out_col       <= '0;
            out_row       <= '0;
            ret_cnt       <= '0;
            idle_cnt      <= '0;
        end else begin
            done          <= 1'b0;
            conv_valid_in <= rd_en;

            if (ret_ok) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= out_row + ROW_W'(1);
                end else begin
                    out_col <= out_col + COL_W'(1);
                end
                ret_cnt <= ret_cnt + RET_W'(1);
            end
            if (wr_en) begin
                wr_addr <= wr_addr + OUT_ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        error    <= 1'b0;
                        rd_addr  <= '0;
                        wr_addr  <= '0;
                        out_col  <= '0;
                        out_row  <= '0;
                        ret_cnt  <= '0;
                        idle_cnt <= '0;
                        rd_en    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (rd_addr == ADDR_LAST) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // The error flag rises on the same edge at which the idle count reaches TIMEOUT.
                    if (bus.conv_valid_out) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (last_ret) begin
                rd_en <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer on an 8x8 frame. It uses a RAM model holding RAM[i]=i and a
// convolution engine model with run-time latency that adds a fixed offset to each pixel.
module tb_conv_frame_sequencer;
    localparam int DW      = 24;
    localparam int IMG     = 8;
    localparam int KS      = 5;
    localparam int AW      = 10;
    localparam int OW      = 10;
    localparam int TMO     = 20;
    localparam int LOGN    = 1024;
    localparam logic [DW-1:0] OFFSET = 24'h100000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    conv_frame_sequencer_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .OUT_ADDR_W(OW)) bus ();

    conv_frame_sequencer #(
        .DATA_WIDTH(DW), .IMG_W(IMG), .IMG_H(IMG), .K(KS),
        .ADDR_W(AW), .OUT_ADDR_W(OW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Input RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= DW'(bus.rd_addr);
    end

    // Engine model. Its latency is selectable at run time, and it can stop returning results.
    int             lat = 10;
    bit             drop_en = 1'b0;
    int             drop_lim = 0;
    int             emitted = 0;
    logic [15:0]    vpipe = '0;
    logic [DW-1:0]  dpipe [16];

    always @(posedge clk) begin
        vpipe    <= {vpipe[14:0], bus.conv_valid_in};
        dpipe[0] <= bus.conv_data_in + OFFSET;
        for (int i = 1; i < 16; i++) dpipe[i] <= dpipe[i-1];
        if (bus.conv_valid_out) emitted <= emitted + 1;
    end

    assign bus.conv_valid_out = vpipe[lat-1] && !(drop_en && emitted >= drop_lim);
    assign bus.conv_data_out  = dpipe[lat-1];

    // Event logger, sampled on the falling edge.
    int            cyc = 0;
    int            rd_count = 0, wr_count = 0, done_count = 0, busy_count = 0, ret_count = 0;
    int            rd_log [LOGN];
    int            rd_cyc [LOGN];
    int            wr_addr_log [LOGN];
    logic [DW-1:0] wr_data_log [LOGN];
    int            done_cyc = -1, last_ret_cyc = -1, err_cyc = -1;
    logic          err_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.rd_en) begin
            rd_log[rd_count % LOGN] <= int'(bus.rd_addr);
            rd_cyc[rd_count % LOGN] <= cyc;
            rd_count <= rd_count + 1;
        end
        if (bus.wr_en) begin
            wr_addr_log[wr_count % LOGN] <= int'(bus.wr_addr);
            wr_data_log[wr_count % LOGN] <= bus.wr_data;
            wr_count <= wr_count + 1;
        end
        if (bus.done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
        if (bus.busy) busy_count <= busy_count + 1;
        if (bus.conv_valid_out) begin
            ret_count    <= ret_count + 1;
            last_ret_cyc <= cyc;
        end
        if (bus.error && !err_prev) err_cyc <= cyc;
        err_prev <= bus.error;
    end

    function automatic logic [DW-1:0] exp_pix(int j);
        int idx;
        idx = (KS - 1 + j / 4) * IMG + (KS - 1) + (j % 4);
        return DW'(idx) + OFFSET;
    endfunction

    task automatic pulse_start(output int s);
        @(posedge clk); #1 bus.start = 1'b1; s = cyc;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (done_count > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got %b want 0", bus.error); end
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en got %b want 0", bus.rd_en); end
        checks++; if (bus.conv_valid_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_in got %b want 0", bus.conv_valid_in); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en got %b want 0", bus.wr_en); end
        checks++; if (bus.rd_addr !== '0) begin errors++; $display("[TB] FAIL reset_rd_addr got %0d want 0", bus.rd_addr); end
        checks++; if (bus.wr_addr !== '0) begin errors++; $display("[TB] FAIL reset_wr_addr got %0d want 0", bus.wr_addr); end
    endtask

    task automatic test_single_frame();
        int s, rb, wb, db, bb;
        bit ok, seq_ok;
        lat = 10;
        rb = rd_count; wb = wr_count; db = done_count; bb = busy_count;
        pulse_start(s);
        wait_done(db, 200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL frame_done_wait got timeout want done"); end
        repeat (5) @(posedge clk); #1;
        checks++; if (rd_count - rb !== 64) begin errors++; $display("[TB] FAIL frame_reads got %0d want 64", rd_count - rb); end
        seq_ok = 1'b1;
        for (int i = 0; i < 64; i++) if (rd_log[rb+i] !== i || rd_cyc[rb+i] !== s + 1 + i) seq_ok = 1'b0;
        checks++; if (!seq_ok) begin errors++; $display("[TB] FAIL frame_read_seq got first %0d@%0d want 0@%0d consecutive", rd_log[rb], rd_cyc[rb], s + 1); end
        checks++; if (wr_count - wb !== 16) begin errors++; $display("[TB] FAIL frame_writes got %0d want 16", wr_count - wb); end
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (wr_addr_log[wb+j] !== j || wr_data_log[wb+j] !== exp_pix(j)) begin
                errors++;
                $display("[TB] FAIL frame_write%0d got addr %0d data %h want addr %0d data %h", j, wr_addr_log[wb+j], wr_data_log[wb+j], j, exp_pix(j));
            end
        end
        checks++; if (done_count - db !== 1) begin errors++; $display("[TB] FAIL frame_done_count got %0d want 1", done_count - db); end
        checks++; if (busy_count - bb !== 75) begin errors++; $display("[TB] FAIL frame_busy_cycles got %0d want 75", busy_count - bb); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("[TB] FAIL frame_error got %b want 0", bus.error); end
    endtask

    task automatic test_start_while_busy();
        int s, rb, wb, db;
        bit ok;
        lat = 10;
        rb = rd_count; wb = wr_count; db = done_count;
        pulse_start(s);
        repeat (4) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (34) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(db, 200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL busy_start_wait got timeout want done"); end
        repeat (5) @(posedge clk); #1;
        checks++; if (rd_count - rb !== 64) begin errors++; $display("[TB] FAIL busy_start_reads got %0d want 64", rd_count - rb); end
        checks++; if (wr_count - wb !== 16) begin errors++; $display("[TB] FAIL busy_start_writes got %0d want 16", wr_count - wb); end
        checks++; if (done_count - db !== 1) begin errors++; $display("[TB] FAIL busy_start_done got %0d want 1", done_count - db); end
        checks++; if (wr_addr_log[wb+15] !== 15) begin errors++; $display("[TB] FAIL busy_start_last_addr got %0d want 15", wr_addr_log[wb+15]); end
    endtask

    task automatic test_back_to_back();
        int s, rb, wb, db;
        bit ok, seen;
        lat = 10;
        rb = rd_count; wb = wr_count; db = done_count;
        pulse_start(s);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL b2b_first_done got timeout want done"); end
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        checks++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== '0) begin errors++; $display("[TB] FAIL b2b_restart got rd_en %b rd_addr %0d want 1 0", bus.rd_en, bus.rd_addr); end
        checks++; if (bus.wr_addr !== '0) begin errors++; $display("[TB] FAIL b2b_wr_addr got %0d want 0", bus.wr_addr); end
        wait_done(db + 1, 200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_second_done got timeout want done"); end
        repeat (5) @(posedge clk); #1;
        checks++; if (done_count - db !== 2) begin errors++; $display("[TB] FAIL b2b_done_count got %0d want 2", done_count - db); end
        checks++; if (rd_count - rb !== 128) begin errors++; $display("[TB] FAIL b2b_reads got %0d want 128", rd_count - rb); end
        checks++; if (wr_count - wb !== 32) begin errors++; $display("[TB] FAIL b2b_writes got %0d want 32", wr_count - wb); end
        checks++; if (wr_addr_log[wb+16] !== 0 || wr_data_log[wb+16] !== exp_pix(0)) begin errors++; $display("[TB] FAIL b2b_second_first_write got addr %0d data %h want 0 %h", wr_addr_log[wb+16], wr_data_log[wb+16], exp_pix(0)); end
    endtask

    task automatic test_timeout();
        int s, wb, db, retb;
        bit ok, seen;
        lat = 10;
        wb = wr_count; db = done_count; retb = ret_count;
        drop_lim = emitted + 60;
        drop_en = 1'b1;
        pulse_start(s);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.error) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL timeout_error_wait got timeout want error"); end
        @(posedge clk); #1;
        checks++; if (err_cyc - last_ret_cyc !== 21) begin errors++; $display("[TB] FAIL timeout_delay got %0d want 21", err_cyc - last_ret_cyc); end
        checks++; if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin errors++; $display("[TB] FAIL timeout_idle got busy %b rd_en %b want 0 0", bus.busy, bus.rd_en); end
        checks++; if (done_count - db !== 0) begin errors++; $display("[TB] FAIL timeout_done got %0d want 0", done_count - db); end
        checks++; if (ret_count - retb !== 60) begin errors++; $display("[TB] FAIL timeout_returns got %0d want 60", ret_count - retb); end
        checks++; if (wr_count - wb !== 12) begin errors++; $display("[TB] FAIL timeout_writes got %0d want 12", wr_count - wb); end
        drop_en = 1'b0;
        repeat (3) @(posedge clk);
        wb = wr_count; db = done_count;
        pulse_start(s);
        checks++; if (bus.error !== 1'b0) begin errors++; $display("[TB] FAIL recover_error_clear got %b want 0", bus.error); end
        wait_done(db, 200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL recover_done_wait got timeout want done"); end
        #1;
        checks++; if (wr_count - wb !== 16) begin errors++; $display("[TB] FAIL recover_writes got %0d want 16", wr_count - wb); end
    endtask

    task automatic test_reset_mid_frame();
        int s, wb, db;
        lat = 10;
        wb = wr_count; db = done_count;
        pulse_start(s);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle got busy %b rd_en %b want 0 0", bus.busy, bus.rd_en); end
        checks++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0) begin errors++; $display("[TB] FAIL midrst_wr got wr_en %b wr_addr %0d want 0 0", bus.wr_en, bus.wr_addr); end
        checks++; if (bus.rd_addr !== '0 || bus.conv_valid_in !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rd got rd_addr %0d valid_in %b want 0 0", bus.rd_addr, bus.conv_valid_in); end
        rst = 1'b0;
        repeat (30) @(posedge clk); #1;
        checks++; if (wr_count - wb !== 0) begin errors++; $display("[TB] FAIL midrst_late_writes got %0d want 0", wr_count - wb); end
        checks++; if (done_count - db !== 0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_quiet got done %0d busy %b want 0 0", done_count - db, bus.busy); end
    endtask

    task automatic test_latency_one();
        int s, wb, db;
        bit ok, addr_ok;
        lat = 1;
        wb = wr_count; db = done_count;
        pulse_start(s);
        wait_done(db, 200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL lat1_done_wait got timeout want done"); end
        repeat (5) @(posedge clk); #1;
        checks++; if (wr_count - wb !== 16) begin errors++; $display("[TB] FAIL lat1_writes got %0d want 16", wr_count - wb); end
        addr_ok = 1'b1;
        for (int j = 0; j < wr_count - wb; j++) if (wr_addr_log[wb+j] >= 16 || wr_addr_log[wb+j] !== j) addr_ok = 1'b0;
        checks++; if (!addr_ok) begin errors++; $display("[TB] FAIL lat1_addrs got last %0d want 0..15", wr_addr_log[wb+15]); end
        checks++; if (done_cyc - last_ret_cyc !== 1) begin errors++; $display("[TB] FAIL lat1_done_timing got %0d want 1", done_cyc - last_ret_cyc); end
        checks++; if (done_count - db !== 1) begin errors++; $display("[TB] FAIL lat1_done_count got %0d want 1", done_count - db); end
        checks++; if (wr_data_log[wb+15] !== exp_pix(15)) begin errors++; $display("[TB] FAIL lat1_last_data got %h want %h", wr_data_log[wb+15], exp_pix(15)); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_single_frame();
        test_start_while_busy();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        test_latency_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
